// File: rtl/pueo_command_decoder_mc.sv
// rtl/pueo_command_decoder_mc.sv - decodes the per-period command word into trigger, run, mode1 and firmware outputs
module pueo_command_decoder_mc #(
    parameter int TRIG_VALID_BIT = 15,
    parameter int TRIG_TIME_BITS = 15,
    parameter int STRETCH        = 2,
    parameter int FW_BYTES       = 1,
    parameter int CNT_BITS       = 16
) (
    input  logic                      sysclk_i,
    input  logic                      rst_i,
    input  logic [31:0]               command_i,
    input  logic                      command_valid_i,
    output logic [TRIG_TIME_BITS-1:0] trig_time_o,
    output logic                      trig_valid_o,
    output logic                      rundo_sync_o,
    output logic                      runrst_o,
    output logic                      runstop_o,
    output logic                      runnoop_live_o,
    output logic                      cmdproc_rst_o,
    output logic [7:0]                cmdproc_tdata,
    output logic                      cmdproc_tvalid,
    output logic                      cmdproc_tlast,
    output logic [8*FW_BYTES-1:0]     fw_tdata,
    output logic                      fw_tvalid,
    output logic [1:0]                fw_mark_o,
    output logic                      fw_partial_drop_o,
    output logic [CNT_BITS-1:0]       trig_count_o,
    output logic [CNT_BITS-1:0]       msg_count_o
);

    localparam int                IDX_W      = (FW_BYTES > 1) ? $clog2(FW_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FW_BYTES - 1);
    localparam logic [2:0]        STRETCH_LD = 3'(STRETCH);

    logic                  message;
    logic                  trig;
    logic [1:0]            runcmd;
    logic [1:0]            mode1type;
    logic [7:0]            mode1data;
    logic                  is_fw;
    logic                  is_special;
    logic                  flush;
    logic                  word_done;
    logic                  unused_ok;

    logic [2:0]            stretch_cnt;
    logic                  stretch_active;
    logic                  do_sync_q;
    logic                  rst_q;
    logic                  stop_q;
    logic                  fw_q;
    logic [IDX_W-1:0]      idx;
    logic [8*FW_BYTES-1:0] shadow;
    logic [8*FW_BYTES-1:0] next_shadow;

    assign message    = command_valid_i && !command_i[31];
    assign trig       = command_valid_i && command_i[TRIG_VALID_BIT];
    assign runcmd     = command_i[27:26];
    assign mode1type  = command_i[25:24];
    assign mode1data  = command_i[23:16];
    assign is_fw      = message && (mode1type == 2'b11);
    assign is_special = message && (mode1type == 2'b00);
    assign flush      = is_special && (mode1data == 8'h01 || mode1data == 8'h02 || mode1data == 8'h03);
    assign word_done  = is_fw && (idx == LAST_IDX);
    assign unused_ok  = ^command_i;

    // Stretched outputs are the latched decode gated by the live counter, so a reload re-decodes them.
    assign stretch_active = (stretch_cnt != 3'd0);
    assign rundo_sync_o   = do_sync_q && stretch_active;
    assign runrst_o       = rst_q && stretch_active;
    assign runstop_o      = stop_q && stretch_active;
    assign fw_tvalid      = fw_q && stretch_active;

    always_comb begin
        next_shadow = shadow;
        for (int i = 0; i < FW_BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                next_shadow[i*8 +: 8] = mode1data;
            end
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_valid_o <= 1'b0;
            trig_time_o  <= '0;
            trig_count_o <= '0;
            msg_count_o  <= '0;
        end else begin
            trig_valid_o <= trig;
            if (trig) begin
                trig_time_o  <= command_i[TRIG_TIME_BITS-1:0];
                trig_count_o <= trig_count_o + CNT_BITS'(1);
            end
            if (message) begin
                msg_count_o <= msg_count_o + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            stretch_cnt       <= 3'd0;
            do_sync_q         <= 1'b0;
            rst_q             <= 1'b0;
            stop_q            <= 1'b0;
            fw_q              <= 1'b0;
            runnoop_live_o    <= 1'b0;
            cmdproc_rst_o     <= 1'b0;
            cmdproc_tvalid    <= 1'b0;
            cmdproc_tdata     <= 8'h00;
            cmdproc_tlast     <= 1'b0;
            fw_mark_o         <= 2'b00;
            fw_partial_drop_o <= 1'b0;
        end else begin
            runnoop_live_o    <= message && (runcmd == 2'b00);
            cmdproc_rst_o     <= is_special && (mode1data == 8'h01);
            fw_mark_o         <= {is_special && (mode1data == 8'h03), is_special && (mode1data == 8'h02)};
            cmdproc_tvalid    <= message && (mode1type == 2'b01 || mode1type == 2'b11);
            fw_partial_drop_o <= flush && (idx != '0);
            if (message) begin
                stretch_cnt   <= STRETCH_LD;
                do_sync_q     <= (runcmd == 2'b01);
                rst_q         <= (runcmd == 2'b10);
                stop_q        <= (runcmd == 2'b11);
                fw_q          <= word_done;
                cmdproc_tdata <= mode1data;
                cmdproc_tlast <= (mode1type == 2'b11);
            end else if (stretch_active) begin
                stretch_cnt <= stretch_cnt - 3'd1;
            end
        end
    end

    // Packer: a flush discards any partial word rather than emitting it.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            idx      <= '0;
            shadow   <= '0;
            fw_tdata <= '0;
        end else if (flush) begin
            idx    <= '0;
            shadow <= '0;
        end else if (is_fw) begin
            if (word_done) begin
                fw_tdata <= next_shadow;
                idx      <= '0;
                shadow   <= '0;
            end else begin
                shadow <= next_shadow;
                idx    <= idx + IDX_W'(1);
            end
        end
    end

endmodule
